pixel_request_responder: RTL and testbench

Serving end of the window pixel request/receive handshake. It buffers the camera pixel stream in a small FIFO, tags each pixel with its original-frame coordinates, and answers each `pixel_request` assertion from the detection window controller with exactly one pixel, its `ori_x`/`ori_y` and a one-cycle `pixel_recieve` strobe. It sits between the camera stream and the I2LBS window controller, in the `clk_fpga` domain.

---
 rtl/pixel_request_responder.sv | 133 +++++++++++++
 tb/tb_pixel_request_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_request_responder.sv
// Camera-side FIFO that tags each pixel with its frame coordinates and answers each
// window-controller request assertion with exactly one pixel and a one-cycle strobe.
module pixel_request_responder #(
  parameter int DATA_WIDTH_12                = 12,
  parameter int FRAME_ORIGINAL_CAMERA_WIDTH  = 10,
  parameter int FRAME_ORIGINAL_CAMERA_HEIGHT = 10,
  parameter int FIFO_DEPTH                   = 4
) (
  input  logic                            clk_fpga,
  input  logic                            reset_fpga,
  input  logic                            i_cam_valid,
  input  logic [DATA_WIDTH_12-1:0]        i_cam_pixel,
  output logic                            o_cam_ready,
  input  logic                            i_pixel_request,
  output logic [DATA_WIDTH_12-1:0]        o_pixel,
  output logic [DATA_WIDTH_12-1:0]        o_ori_x,
  output logic [DATA_WIDTH_12-1:0]        o_ori_y,
  output logic                            o_pixel_recieve,
  output logic                            o_frame_end,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [DATA_WIDTH_12-1:0] X_LAST   = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_WIDTH - 1);
  localparam logic [DATA_WIDTH_12-1:0] Y_LAST   = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_HEIGHT - 1);
  localparam logic [LVL_W-1:0]         LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SERVE, HOLD} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH_12-1:0] mem_pix [FIFO_DEPTH];
  logic [DATA_WIDTH_12-1:0] mem_x   [FIFO_DEPTH];
  logic [DATA_WIDTH_12-1:0] mem_y   [FIFO_DEPTH];

  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [LVL_W-1:0]         level;
  logic [DATA_WIDTH_12-1:0] wr_x, wr_y;
  logic                     full, empty, push, pop;

  logic [DATA_WIDTH_12-1:0] pixel_p1, ori_x_p1, ori_y_p1;
  logic                     vld_p1;

  assign full        = (level == LVL_FULL);
  assign empty       = (level == '0);
  assign o_cam_ready = !full && !reset_fpga;
  assign push        = i_cam_valid && o_cam_ready;

  // ---- stage p0: FIFO storage and write-coordinate tagging
  always_ff @(posedge clk_fpga) begin
    if (push) begin
      mem_pix[wr_ptr] <= i_cam_pixel;
      mem_x[wr_ptr]   <= wr_x;
      mem_y[wr_ptr]   <= wr_y;
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      wr_x   <= '0;
      wr_y   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (wr_x == X_LAST) begin
          wr_x <= '0;
          wr_y <= (wr_y == Y_LAST) ? '0 : wr_y + DATA_WIDTH_12'(1);
        end else begin
          wr_x <= wr_x + DATA_WIDTH_12'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // ---- read handshake FSM: one pop per request assertion
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (i_pixel_request && !empty) begin
          pop       = 1'b1;
          state_nxt = SERVE;
        end
      end
      SERVE:   state_nxt = HOLD;
      HOLD:    if (!i_pixel_request) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: delivered pixel registers, held until the next delivery
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      pixel_p1 <= '0;
      ori_x_p1 <= '0;
      ori_y_p1 <= '0;
    end else if (pop) begin
      pixel_p1 <= mem_pix[rd_ptr];
      ori_x_p1 <= mem_x[rd_ptr];
      ori_y_p1 <= mem_y[rd_ptr];
    end
  end

  assign vld_p1          = (state == SERVE);
  assign o_pixel         = pixel_p1;
  assign o_ori_x         = ori_x_p1;
  assign o_ori_y         = ori_y_p1;
  assign o_pixel_recieve = vld_p1;
  assign o_frame_end     = vld_p1 && (ori_x_p1 == X_LAST) && (ori_y_p1 == Y_LAST);
  assign o_fifo_level    = level;

endmodule

// File: tb/tb_pixel_request_responder.sv
// Bench for pixel_request_responder: occupancy/handshake reference model with a
// scoreboard of tagged pixels, table-checked delivery log and directed corner sequences.
module tb_pixel_request_responder;

  localparam int DEPTH = 4;

  logic        clk_fpga = 1'b0;
  logic        reset_fpga = 1'b1;
  logic        cam_valid = 1'b0;
  logic [11:0] cam_pixel = '0;
  logic        cam_ready;
  logic        pixel_request = 1'b0;
  logic [11:0] pixel, ori_x, ori_y;
  logic        pixel_recieve, frame_end;
  logic [2:0]  fifo_level;

  pixel_request_responder #(
    .DATA_WIDTH_12(12),
    .FRAME_ORIGINAL_CAMERA_WIDTH(10),
    .FRAME_ORIGINAL_CAMERA_HEIGHT(10),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_fpga(clk_fpga),
    .reset_fpga(reset_fpga),
    .i_cam_valid(cam_valid),
    .i_cam_pixel(cam_pixel),
    .o_cam_ready(cam_ready),
    .i_pixel_request(pixel_request),
    .o_pixel(pixel),
    .o_ori_x(ori_x),
    .o_ori_y(ori_y),
    .o_pixel_recieve(pixel_recieve),
    .o_frame_end(frame_end),
    .o_fifo_level(fifo_level)
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct packed { logic [11:0] pix; logic [11:0] x; logic [11:0] y; } ent_t;
  typedef struct packed { logic [11:0] pix; logic [11:0] x; logic [11:0] y; logic fe; } log_t;
  typedef struct { int idx; logic [11:0] pix; logic [11:0] x; logic [11:0] y; logic fe; } vec_t;

  ent_t sb[$];
  log_t dlog[$];
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;

  int          mlevel = 0;
  int          mstate = 0;
  logic [11:0] mx = '0, my = '0;
  logic [11:0] lp = '0, lx = '0, ly = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  // Reference model of occupancy, write coordinates and the handshake, stepped at each edge.
  initial begin
    logic mpush, mpop;
    forever begin
      @(posedge clk_fpga);
      if (reset_fpga) begin
        mlevel = 0; mstate = 0; mx = '0; my = '0;
        lp = '0; lx = '0; ly = '0;
        sb.delete();
      end else begin
        mpop  = (mstate == 0) && pixel_request && (mlevel > 0);
        mpush = cam_valid && (mlevel < DEPTH);
        if (mpush) begin
          sb.push_back('{cam_pixel, mx, my});
          if (mx == 12'd9) begin
            mx = '0;
            my = (my == 12'd9) ? 12'd0 : my + 12'd1;
          end else begin
            mx = mx + 12'd1;
          end
        end
        mlevel = mlevel + int'(mpush) - int'(mpop);
        case (mstate)
          0:       mstate = mpop ? 1 : 0;
          1:       mstate = 2;
          default: mstate = pixel_request ? 2 : 0;
        endcase
      end
    end
  end

  // Output monitor: scoreboard pop on each strobe, held-value and occupancy checks every cycle.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk_fpga);
      chk("strobe", pixel_recieve, mstate == 1);
      if (pixel_recieve) begin
        chk("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          lp = e.pix; lx = e.x; ly = e.y;
        end
        dlog.push_back('{pixel, ori_x, ori_y, frame_end});
        strobes++;
      end
      chk("o_pixel", pixel, lp);
      chk("o_ori_x", ori_x, lx);
      chk("o_ori_y", ori_y, ly);
      chk("frame_end", frame_end, (mstate == 1) && lx == 12'd9 && ly == 12'd9);
      chk("fifo_level", fifo_level, mlevel);
      chk("cam_ready", cam_ready, !reset_fpga && mlevel < DEPTH);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic do_reset();
    reset_fpga = 1'b1; cam_valid = 1'b0; pixel_request = 1'b0;
    tick();
    chk("ready_in_reset", cam_ready, 0);
    tick();
    reset_fpga = 1'b0;
    #1;
    chk("ready_after_reset", cam_ready, 1);
    chk("level_after_reset", fifo_level, 0);
    chk("pixel_after_reset", pixel, 0);
    chk("strobe_after_reset", pixel_recieve, 0);
  endtask

  task automatic push_px(input logic [11:0] p);
    cam_pixel = p; cam_valid = 1'b1;
    tick();
    cam_valid = 1'b0;
  endtask

  task automatic serve();
    int n;
    pixel_request = 1'b1;
    tick();
    n = 1;
    while (!pixel_recieve && n < 20) begin
      tick();
      n++;
    end
    chk("serve_strobe", pixel_recieve, 1);
    pixel_request = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    vec_t tbl[6];
    ent_t exp3[3];
    int   s0;

    tbl[0] = '{0,   12'd0,   12'd0, 12'd0, 1'b0};
    tbl[1] = '{9,   12'd9,   12'd9, 12'd0, 1'b0};
    tbl[2] = '{10,  12'd10,  12'd0, 12'd1, 1'b0};
    tbl[3] = '{55,  12'd55,  12'd5, 12'd5, 1'b0};
    tbl[4] = '{99,  12'd99,  12'd9, 12'd9, 1'b1};
    tbl[5] = '{100, 12'd100, 12'd0, 12'd0, 1'b0};

    // Basic delivery
    do_reset();
    push_px(12'h011); push_px(12'h022); push_px(12'h033);
    chk("basic_level3", fifo_level, 3);
    s0 = strobes;
    pixel_request = 1'b1;
    tick();
    chk("basic_strobe", pixel_recieve, 1);
    chk("basic_pixel", pixel, 12'h011);
    chk("basic_x", ori_x, 0);
    chk("basic_y", ori_y, 0);
    chk("basic_level2", fifo_level, 2);
    repeat (4) tick();
    pixel_request = 1'b0;
    tick(); tick();
    chk("basic_one_strobe", strobes - s0, 1);

    // Full FIFO
    do_reset();
    dlog.delete();
    cam_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cam_pixel = 12'h100 + 12'(i);
      tick();
      if (i == 3) chk("full_ready_drop", cam_ready, 0);
    end
    cam_valid = 1'b0;
    chk("full_level4", fifo_level, 4);
    serve();
    chk("full_ready_back", cam_ready, 1);
    repeat (3) serve();
    chk("full_count", dlog.size(), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++)
      chk("full_order", dlog[i].pix, 12'h100 + 12'(i));

    // Coordinate wrap across a whole frame
    do_reset();
    dlog.delete();
    fork
      begin
        int n;
        for (int i = 0; i <= 100; i++) begin
          cam_pixel = 12'(i); cam_valid = 1'b1;
          n = 0;
          while (!cam_ready && n < 50) begin tick(); n++; end
          tick();
        end
        cam_valid = 1'b0;
      end
      begin
        for (int k = 0; k <= 100; k++) serve();
      end
    join
    chk("wrap_count", dlog.size(), 101);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].idx < dlog.size()) begin
        chk("wrap_pix", dlog[tbl[i].idx].pix, tbl[i].pix);
        chk("wrap_x",   dlog[tbl[i].idx].x,   tbl[i].x);
        chk("wrap_y",   dlog[tbl[i].idx].y,   tbl[i].y);
        chk("wrap_fe",  dlog[tbl[i].idx].fe,  tbl[i].fe);
      end
    end

    // Request while empty
    do_reset();
    pixel_request = 1'b1;
    repeat (4) tick();
    chk("empty_no_strobe", pixel_recieve, 0);
    cam_pixel = 12'h0AB; cam_valid = 1'b1;
    tick();
    cam_valid = 1'b0;
    chk("empty_not_yet", pixel_recieve, 0);
    tick();
    chk("empty_strobe", pixel_recieve, 1);
    chk("empty_pixel", pixel, 12'h0AB);
    pixel_request = 1'b0;
    tick(); tick();

    // Reset in the SERVE cycle
    do_reset();
    push_px(12'h051); push_px(12'h052); push_px(12'h053);
    pixel_request = 1'b1;
    tick();
    chk("mid_serve_strobe", pixel_recieve, 1);
    chk("mid_serve_level", fifo_level, 2);
    reset_fpga = 1'b1;
    #1;
    chk("mid_ready_low", cam_ready, 0);
    tick();
    chk("mid_strobe0", pixel_recieve, 0);
    chk("mid_pixel0", pixel, 0);
    chk("mid_x0", ori_x, 0);
    chk("mid_y0", ori_y, 0);
    chk("mid_level0", fifo_level, 0);
    reset_fpga = 1'b0;
    s0 = strobes;
    repeat (3) tick();
    chk("mid_no_strobe", strobes - s0, 0);
    pixel_request = 1'b0;
    tick();
    push_px(12'h077);
    serve();
    chk("mid_next_pixel", pixel, 12'h077);
    chk("mid_next_x", ori_x, 0);
    chk("mid_next_y", ori_y, 0);

    // Simultaneous push and pop
    do_reset();
    push_px(12'h0A1); push_px(12'h0A2);
    chk("sim_level2", fifo_level, 2);
    dlog.delete();
    pixel_request = 1'b1; cam_pixel = 12'h0A3; cam_valid = 1'b1;
    tick();
    cam_valid = 1'b0;
    chk("sim_level_hold", fifo_level, 2);
    chk("sim_pixel", pixel, 12'h0A1);
    pixel_request = 1'b0;
    tick(); tick();
    serve(); serve();
    exp3[0] = '{12'h0A1, 12'd0, 12'd0};
    exp3[1] = '{12'h0A2, 12'd1, 12'd0};
    exp3[2] = '{12'h0A3, 12'd2, 12'd0};
    chk("sim_count", dlog.size(), 3);
    for (int i = 0; i < 3 && i < dlog.size(); i++) begin
      chk("sim_order_pix", dlog[i].pix, exp3[i].pix);
      chk("sim_order_x",   dlog[i].x,   exp3[i].x);
    end
    chk("sim_level_end", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
